wb_scoreboard: RTL

WB_SCOREBOARD -- requirements
Module: wb_scoreboard

---
 rtl/wb_scoreboard_pkg.sv | 22 ++
 rtl/wb_scoreboard_if.sv | 41 ++++
 rtl/wb_scoreboard_sb_entry.sv | 27 ++
 rtl/wb_scoreboard.sv | 117 +++++++++++
 4 files changed

// File: rtl/wb_scoreboard_pkg.sv
// Shared definitions for the write-back scoreboard: register-address width,
// in-flight counter width and the drain FSM state encoding.
package wb_scoreboard_pkg;

    // Register-address width: 2**D architectural registers.
    localparam int D  = 5;
    // Per-register in-flight counter width: up to 2**CW-1 outstanding writes.
    localparam int CW = 2;

    // Drain FSM states.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2
    } sb_state_e;

    // Largest value a cw-bit in-flight counter may hold.
    function automatic int cnt_limit(input int cw);
        return (1 << cw) - 1;
    endfunction

endpackage

// File: rtl/wb_scoreboard_if.sv
// Bus between decode/write-back and the scoreboard.
//
// Handshake: decode drives issue_valid together with its operands; the
// scoreboard answers combinationally with stall in the same cycle. An issue is
// taken only in a cycle where issue_valid=1, stall=0 and flush=0. Retires
// (wb_valid) have no back-pressure and are always absorbed. drain_req is a
// level request; drain_ack is a single-cycle completion pulse.
interface wb_scoreboard_if #(
    parameter int D = wb_scoreboard_pkg::D
);
    logic           issue_valid;
    logic [D-1:0]   issue_rd;
    logic           issue_RegWrite;
    logic [D-1:0]   rs;
    logic [D-1:0]   rt;
    logic           use_rs;
    logic           use_rt;
    logic           flush;
    logic           wb_valid;
    logic [D-1:0]   wb_rd;
    logic           wb_RegWrite;
    logic           drain_req;
    logic           stall;
    logic           drain_ack;
    logic [2**D-1:0] pending;
    // Debug view of the drain FSM.
    wb_scoreboard_pkg::sb_state_e state;

    modport master (
        output issue_valid, issue_rd, issue_RegWrite, rs, rt, use_rs, use_rt,
        output flush, wb_valid, wb_rd, wb_RegWrite, drain_req,
        input  stall, drain_ack, pending, state
    );

    modport slave (
        input  issue_valid, issue_rd, issue_RegWrite, rs, rt, use_rs, use_rt,
        input  flush, wb_valid, wb_rd, wb_RegWrite, drain_req,
        output stall, drain_ack, pending, state
    );

endinterface

// File: rtl/wb_scoreboard_sb_entry.sv
// One scoreboard entry: saturating in-flight write counter for a single
// architectural register. Simultaneous inc and dec cancel out.
module sb_entry #(
    parameter int CW = wb_scoreboard_pkg::CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          nonzero
);

    // Counter update: never wraps above the maximum or below zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && (count != '1)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/wb_scoreboard.sv
// Write-back scoreboard: tracks outstanding register writes between decode and
// write-back, stalls decode on RAW hazards or counter saturation, and supports
// a drain request that waits for every in-flight write to retire.
module wb_scoreboard #(
    parameter int D  = wb_scoreboard_pkg::D,
    parameter int CW = wb_scoreboard_pkg::CW
) (
    input  logic         clk,
    input  logic         reset,
    wb_scoreboard_if.slave bus
);
    import wb_scoreboard_pkg::*;

    localparam int            N       = 2**D;
    localparam logic [CW-1:0] CNT_MAX = CW'(cnt_limit(CW));

    sb_state_e      state;
    sb_state_e      state_next;
    logic [CW-1:0]  cnt [N];
    logic [N-1:0]   nonzero;
    logic [N-1:0]   nz_next;
    logic [N-1:0]   pending_q;
    logic           retire;
    logic           issue_wr;
    logic           inc_en;
    logic           hazard_rs;
    logic           hazard_rt;
    logic           full_rd;
    logic           stall;
    logic           drained_next;

    // Register 0 is hard-wired: never tracked, never pending.
    assign cnt[0]     = '0;
    assign nonzero[0] = 1'b0;
    assign nz_next[0] = 1'b0;

    assign retire   = bus.wb_valid && bus.wb_RegWrite && (bus.wb_rd != '0);
    assign issue_wr = bus.issue_RegWrite && (bus.issue_rd != '0);

    // Source hazards, with write-back bypass when the last in-flight write of a
    // source retires in this very cycle; destination saturation is not bypassed.
    always_comb begin
        hazard_rs = bus.use_rs && (bus.rs != '0) && (cnt[bus.rs] != '0);
        if (retire && (bus.wb_rd == bus.rs) && (cnt[bus.rs] == CW'(1))) begin
            hazard_rs = 1'b0;
        end
        hazard_rt = bus.use_rt && (bus.rt != '0) && (cnt[bus.rt] != '0);
        if (retire && (bus.wb_rd == bus.rt) && (cnt[bus.rt] == CW'(1))) begin
            hazard_rt = 1'b0;
        end
        full_rd = issue_wr && (cnt[bus.issue_rd] == CNT_MAX);
    end

    assign stall  = bus.issue_valid &&
                    (hazard_rs || hazard_rt || full_rd || (state != RUN));
    assign inc_en = bus.issue_valid && !stall && !bus.flush &&
                    (state == RUN) && issue_wr;

    for (genvar i = 1; i < N; i++) begin : g_entry
        logic inc;
        logic dec;
        assign inc = inc_en && (bus.issue_rd == D'(i));
        assign dec = retire && (bus.wb_rd == D'(i));

        sb_entry #(.CW(CW)) u_entry (
            .clk     (clk),
            .reset   (reset),
            .inc     (inc),
            .dec     (dec),
            .count   (cnt[i]),
            .nonzero (nonzero[i])
        );

        // Whether this entry is still non-zero after the coming edge.
        assign nz_next[i] = (inc && !dec) ? 1'b1 :
                            (dec && !inc) ? (cnt[i] > CW'(1)) : nonzero[i];
    end

    // The drain completes on the cycle whose retire empties the last entry.
    assign drained_next = ~|nz_next;

    // Drain FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Drain FSM next state: RUN -> DRAIN on request, DRAIN -> ACK when empty,
    // ACK lasts exactly one cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN:     if (bus.drain_req) state_next = DRAIN;
            DRAIN:   if (drained_next)  state_next = ACK;
            ACK:     state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Pending flags lag the counters by one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= nonzero;
        end
    end

    assign bus.stall     = stall;
    assign bus.drain_ack = (state == ACK);
    assign bus.pending   = pending_q;
    assign bus.state     = state;

endmodule
